bit_serial_addsub_ctrl: RTL and testbench
=========================================

// Module: bit_serial_addsub_ctrl
// PURPOSE
//  Sequencer that time-shares one 1-bit full adder/full subtractor cell (NAND-built) across WIDTH-bit operands.
//  Latches operands, walks them LSB-first through the cell for WIDTH cycles, keeps a carry/borrow register.
//  Returns the WIDTH-bit sum or difference plus the final carry/borrow over a start/busy/done handshake.
//  Sits between the challenge top-level and the shared 1-bit cell as its only user.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  op         in   1      0 = add (a+b), 1 = subtract (a-b); latched with start
//  a          in   WIDTH  operand A; latched with start
//  b          in   WIDTH  operand B; latched with start
//  busy       out  1      high whenever state != IDLE
//  done       out  1      one-cycle pulse: result/cout_borr valid
//  result     out  WIDTH  sum or difference, mod 2^WIDTH
//  cout_borr  out  1      add: carry out of MSB; sub: borrow out (1 iff a < b unsigned)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; busy=0, done=0, result=0, cout_borr=0.
//   Counter, carry reg, operand regs cleared. rst wins over every other input.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 at edge k -> latch a, b, op; bit_cnt=0; c=0; go to RUN. start=0 -> stay.
//  RUN: one bit per edge, bit i = bit_cnt.
//   add: s = a[i]^b[i]^c; c' = a[i]&b[i] | c&(a[i]^b[i]).
//   sub: d = a[i]^b[i]^c; c' = ~a[i]&b[i] | c&~(a[i]^b[i]).
//   s/d shifted into an internal shift reg; bit_cnt++.
//   Edge k+WIDTH (after processing bit WIDTH-1) -> DONE.
//   At that same edge: result <= shift reg; cout_borr <= c'.
//  DONE: done=1 for exactly one cycle, then -> IDLE.
//  Latency: done high in the cycle following edge k+WIDTH, i.e. WIDTH+1 edges after start is sampled.
//  Throughput: next start accepted at edge k+WIDTH+2; max one op per WIDTH+2 cycles.
//  result/cout_borr change only on entry to DONE.
//   Held stable through later RUN phases until the next completion.
//  start while busy (RUN or DONE): ignored, not queued; a/b/op changes while busy have no effect.
//  start held high continuously: ops back-to-back at the throughput above, each using inputs present at its IDLE edge.
//  rst mid-RUN/DONE: aborts op, no done pulse, outputs go to reset values.
//  bit_cnt is clog2(WIDTH)+1 bits wide; never wraps within one op.
// TESTING (WIDTH=8)
//  1. add a=8'hFF, b=8'h01 -> done exactly 9 cycles after start edge; result=8'h00, cout_borr=1.
//  2. sub a=8'h05, b=8'h07 -> result=8'hFE, cout_borr=1.
//     sub a=8'h07, b=8'h05 -> result=8'h02, cout_borr=0.
//  3. Pulse start again 3 cycles into RUN with a=8'h11 -> ignored.
//     Single done; result from first op; busy=1 for 9 cycles.
//  4. rst=1 at RUN bit 4 -> next cycle busy=0, done=0, result=0; no done pulse follows; new start works normally.
//  5. start tied high, ops add 8'h10+8'h20 then sub 8'h10-8'h20 -> done every 10 cycles.
//     Results 8'h30/0 then 8'hF0/1.
//  6. 1000 random a,b,op vs behavioural a+b / a-b model:
//     result and cout_borr match; done never asserted when busy was 0 the previous cycle.

Source files
------------

// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one NAND-built 1-bit full adder/subtractor cell
// reused across WIDTH cycles, LSB first, with a start/busy/done handshake.
module bit_serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_borr
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic               c_r;
    logic               op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   result_r;
    logic               cout_borr_r;
    logic [1:0]         cell_s;
    logic [WIDTH-1:0]   shift_next_s;
    logic               last_bit_s;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    function automatic logic xor_n(input logic x, input logic y);
        logic m;
        m = nand2(x, y);
        return nand2(nand2(x, m), nand2(y, m));
    endfunction

    // Subtraction reuses the adder carry chain on ~a: the carry out becomes the borrow.
    function automatic logic [1:0] addsub_cell(input logic ai, input logic bi,
                                               input logic ci, input logic sub);
        logic ax;
        logic p;
        logic s;
        logic co;
        ax = xor_n(ai, sub);
        p  = xor_n(ax, bi);
        s  = xor_n(xor_n(ai, bi), ci);
        co = nand2(nand2(ax, bi), nand2(ci, p));
        return {co, s};
    endfunction

    assign cell_s       = addsub_cell(a_r[0], b_r[0], c_r, op_r);
    assign shift_next_s = {cell_s[0], shift_r[WIDTH-1:1]};
    assign last_bit_s   = (bit_cnt_r == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            ST_RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand capture, serial datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= {CNT_W{1'b0}};
            c_r         <= 1'b0;
            op_r        <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            cout_borr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        op_r      <= op;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        c_r       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Operands shift right so the cell always sees bit 0.
                    a_r       <= {1'b0, a_r[WIDTH-1:1]};
                    b_r       <= {1'b0, b_r[WIDTH-1:1]};
                    shift_r   <= shift_next_s;
                    c_r       <= cell_s[1];
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        result_r    <= shift_next_s;
                        cout_borr_r <= cell_s[1];
                    end
                end
                ST_DONE: begin
                    bit_cnt_r <= bit_cnt_r;
                end
                default: begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign result    = result_r;
    assign cout_borr = cout_borr_r;

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Scoreboard bench for bit_serial_addsub_ctrl (WIDTH=8): directed vectors plus a
// random sweep against an arithmetic model; a monitor checks every done pulse.
module tb_bit_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout_borr;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_done = 0;

    bit_serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout_borr(cout_borr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub, input int k);
        exp_t     e;
        logic [W:0] s;
        if (sub) begin
            e.r = x - y;
            e.c = (x < y);
        end else begin
            s   = {1'b0, x} + {1'b0, y};
            e.r = s[W-1:0];
            e.c = s[W];
        end
        e.cyc = k;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse, tracks busy run length
    logic prev_busy = 1'b0;
    int   run_len = 0;
    bit   aborted = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_done = n_done + 1;
            check("done_prev_busy", 32'(prev_busy), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("cout_borr", 32'(cout_borr), 32'(e.c));
                check("latency", 32'(cyc - e.cyc), 32'(W));
            end
        end
        if (rst && busy) aborted = 1'b1;
        if (busy) begin
            run_len = run_len + 1;
        end else if (run_len > 0) begin
            if (!aborted) check("busy_len", 32'(run_len), 32'(W + 1));
            run_len = 0;
            aborted = 1'b0;
        end
        prev_busy = busy;
    end

    // Waits for IDLE, presents one request for one edge; returns at the negedge after it
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        start = 1'b1; a = x; b = y; op = sub;
        @(negedge clk);
        if (push) sb.push_back(model(x, y, sub, cyc));
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard = guard + 1;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int k;
        int d0;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout_borr), 32'd0);

        // directed add / sub vectors with hand-computed results
        issue(8'hFF, 8'h01, 1'b0, 1'b1);
        drain();
        check("t1_result", 32'(result), 32'h00);
        check("t1_cout", 32'(cout_borr), 32'd1);
        issue(8'h05, 8'h07, 1'b1, 1'b1);
        drain();
        check("t2a_result", 32'(result), 32'hFE);
        check("t2a_borrow", 32'(cout_borr), 32'd1);
        issue(8'h07, 8'h05, 1'b1, 1'b1);
        drain();
        check("t2b_result", 32'(result), 32'h02);
        check("t2b_borrow", 32'(cout_borr), 32'd0);

        // start pulse during RUN must be ignored
        d0 = n_done;
        issue(8'h22, 8'h33, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h11; op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("t3_single_done", 32'(n_done - d0), 32'd1);
        check("t3_result", 32'(result), 32'h55);

        // reset while bit 4 is being processed
        d0 = n_done;
        issue(8'h3C, 8'h0F, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_result", 32'(result), 32'd0);
        check("t4_cout", 32'(cout_borr), 32'd0);
        repeat (12) @(negedge clk);
        check("t4_no_done", 32'(n_done - d0), 32'd0);
        issue(8'h40, 8'h41, 1'b0, 1'b1);
        drain();
        check("t4_after", 32'(result), 32'h81);

        // start held high: back-to-back ops every W+2 cycles
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; op = 1'b0;
        @(negedge clk);
        k = cyc;
        sb.push_back('{r: 8'h30, c: 1'b0, cyc: k});
        a = 8'h10; b = 8'h20; op = 1'b1;
        sb.push_back('{r: 8'hF0, c: 1'b1, cyc: k + W + 2});
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        drain();
        check("t5_result", 32'(result), 32'hF0);
        check("t5_borrow", 32'(cout_borr), 32'd1);

        // random sweep against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            s = 1'($urandom);
            issue(x, y, s, 1'b1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
